ps2_keycode_rx: RTL and testbench
=================================

// Module: ps2_keycode_rx
// PURPOSE
// - PS/2 keyboard receiver. Deframes PS/2 device-to-host frames and decodes the set-2 make/break/E0 prefixes.
// - Produces the held 8-bit keycode that the game logic (doodle movement, game_state) consumes alongside the VGA screen.
// - Sits between the board PS/2 pins and vga_screen.keycode.
// PARAMETERS
// - FILTER_LEN   8        consecutive equal samples needed before the filtered ps2_clk/ps2_data changes value
// - TIMEOUT_CYC  100000   Clk cycles (2 ms @ 50 MHz) allowed between falling edges inside a frame
// PORTS
// - Clk        in   1  system clock, 50 MHz
// - Reset      in   1  asynchronous, active-high reset
// - ps2_clk    in   1  raw PS/2 clock pin (async to Clk)
// - ps2_data   in   1  raw PS/2 data pin (async to Clk)
// - keycode    out  8  currently held key scan code; 8'h00 = no key held
// - key_ext    out  1  held key was E0-prefixed; valid while keycode != 0
// - key_valid  out  1  one-cycle pulse: a make or break event has been decoded
// - key_break  out  1  qualifies key_valid: 1 = break event, 0 = make event
// - scan_code  out  8  code byte of the last event; updated with key_valid
// - frame_err  out  1  one-cycle pulse on a stop, parity or timeout error
// BEHAVIOUR
// - Reset values:
//   - all outputs 0; FSM in IDLE; ext/break flags 0
//   - filtered clk and data = 1; timeout counter 0
//   - Reset mid-frame aborts the frame silently (no frame_err).
// - Input conditioning:
//   - 2-flop synchroniser on each pin, then the glitch filter.
//   - A falling edge is a 1->0 transition of filtered clk; it is detected in the cycle after the filter flips.
// - FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE. Each falling edge samples filtered data once.
//   - IDLE, sampled 0: start bit. Clear the bit count and go to DATA. Sampled 1: stay in IDLE, no error.
//   - DATA: shift in LSB first. After 8 bits, go to PARITY.
//   - PARITY: record the bit. Odd parity is checked over data + parity.
//   - STOP, sampled 1: byte accepted. Sampled 0: frame_err, byte dropped. Either way, go to IDLE.
// - Timeout:
//   - The counter clears on every falling edge and in IDLE.
//   - Reaching TIMEOUT_CYC outside IDLE forces IDLE and pulses frame_err.
//   - The counter saturates; it does not wrap.
// - Byte decode, registered 1 cycle after the stop-bit edge:
//   - 8'hE0: set ext flag. No event.
//   - 8'hF0: set break flag. No event.
//   - Any other byte: pulse key_valid and load scan_code. Drive key_break = break flag. Then clear both flags.
//     - Make: keycode <= byte, key_ext <= ext flag. A new make overwrites the held key; typematic repeats re-load the same value.
//     - Break matching the held {ext, keycode}: keycode <= 0, key_ext <= 0.
//     - Break of another key: event still pulses, keycode unchanged.
//   - A frame_err clears the ext and break flags, so no half-prefixed sequence survives.
// - Latency: key_valid asserts 1 + FILTER_LEN + 2 Clk cycles after the raw stop-bit falling edge at the pin.
// CONFIGURATION
// - PS2_PARITY_CHECK_EN defined: a parity mismatch at STOP drops the byte and pulses frame_err. No decode takes place.
// - Not defined: the parity bit is sampled but ignored. Only a stop-bit error or timeout raises frame_err.
// STRUCTURE
// - Package ps2_pkg:
//   - typedef enum {IDLE, DATA, PARITY, STOP} ps2_state_t
//   - localparams PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, KEY_NONE = 8'h00
// - Sub-module ps2_filter, instantiated twice (one per pin): synchroniser, FILTER_LEN glitch filter, fall-edge pulse output.
// - Top level: FSM, shift register, timeout counter, prefix decoder, held-key register.
// TESTING
// - Make/break: send 1C then F0,1C. Expect a make pulse with keycode=1C, then a break pulse with keycode=00 and key_break=1.
// - Extended key: send E0,74 then E0,F0,74. Expect keycode=74 with key_ext=1, then 00 with key_ext=0.
// - Overlap: make 1D, make 1C, break 1D. Expect keycode=1C after the break, plus a key_valid break pulse with scan_code=1D.
// - Errors:
//   - Stop bit 0 -> frame_err, keycode unchanged.
//   - Clock stalls for 150000 cycles mid-DATA -> frame_err, then the FSM is in IDLE. The next good frame 29 decodes correctly.
//   - PS2_PARITY_CHECK_EN defined: bad parity on 1C -> frame_err and no key_valid. Not defined: keycode=1C.
// - Glitches and reset:
//   - A 3-cycle ps2_clk low pulse (FILTER_LEN=8) does not shift a bit.
//   - Reset asserted after 5 data bits, then released: outputs 00, no frame_err, and the next frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 keycode receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_BRK  = 8'hF0;
   localparam logic [7:0] KEY_NONE = 8'h00;

   // Odd parity holds when data plus parity carry an odd number of ones.
   function automatic logic odd_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// Pin conditioner: 2-flop synchroniser, run-length glitch filter and
// a fall pulse asserted the cycle after the filtered level drops.
module ps2_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic fall_o
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          s1_q;
   logic          s2_q;
   logic          filt_q;
   logic          filt_d;
   logic          prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (s2_q != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         filt_q <= 1'b1;
         prev_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         s1_q   <= pin_i;
         s2_q   <= s1_q;
         filt_q <= filt_d;
         prev_q <= filt_q;
         cnt_q  <= cnt_d;
      end
   end

   assign level_o = filt_q;
   assign fall_o  = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host deframer with set-2 E0/F0 prefix decode and held key.
// Define PS2_PARITY_CHECK_EN to drop bytes whose odd parity fails.
import ps2_pkg::*;

module ps2_keycode_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       key_ext,
   output logic       key_valid,
   output logic       key_break,
   output logic [7:0] scan_code,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic          clk_fall;
   logic          clk_lvl_unused;
   logic          dat_lvl;
   logic          dat_fall_unused;
   ps2_state_t    state_q;
   ps2_state_t    state_d;
   logic [2:0]    bit_q;
   logic [2:0]    bit_d;
   logic [7:0]    sh_q;
   logic [7:0]    sh_d;
   logic [TW-1:0] to_q;
   logic [TW-1:0] to_d;
   logic          tmo;
   logic          byte_ok;
   logic          fr_err;
   logic          ext_q;
   logic          brk_q;

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .pin_i   (ps2_clk),
      .level_o (clk_lvl_unused),
      .fall_o  (clk_fall)
   );

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_flt (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .pin_i   (ps2_data),
      .level_o (dat_lvl),
      .fall_o  (dat_fall_unused)
   );

   assign tmo = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYC));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tmo) begin
         state_d = IDLE;
      end else if (clk_fall) begin
         unique case (state_q)
            IDLE:    if (!dat_lvl) state_d = DATA;
            DATA:    if (bit_q == 3'd7) state_d = PARITY;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   logic par_q;
   logic par_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) par_q <= 1'b0;
      else       par_q <= par_d;
   end
`endif

   always_comb begin
      bit_d   = bit_q;
      sh_d    = sh_q;
      byte_ok = 1'b0;
      fr_err  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_d   = par_q;
`endif
      if (state_q == IDLE || clk_fall) to_d = '0;
      else if (to_q != TW'(TIMEOUT_CYC)) to_d = to_q + TW'(1);
      else to_d = to_q;
      if (tmo) begin
         fr_err = 1'b1;
      end else if (clk_fall) begin
         unique case (state_q)
            IDLE: bit_d = '0;
            DATA: begin
               sh_d  = {dat_lvl, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_d = dat_lvl;
`endif
            end
            STOP: begin
               if (!dat_lvl) fr_err = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
               else if (!odd_ok(sh_q, par_q)) fr_err = 1'b1;
`endif
               else byte_ok = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bit_q <= '0;
         sh_q  <= '0;
         to_q  <= '0;
      end else begin
         bit_q <= bit_d;
         sh_q  <= sh_d;
         to_q  <= to_d;
      end
   end

   // Prefix flags live only until the next code byte or a bad frame.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         keycode   <= KEY_NONE;
         key_ext   <= 1'b0;
         key_valid <= 1'b0;
         key_break <= 1'b0;
         scan_code <= '0;
         frame_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= fr_err;
         if (fr_err) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end else if (byte_ok) begin
            if (sh_q == PS2_EXT) begin
               ext_q <= 1'b1;
            end else if (sh_q == PS2_BRK) begin
               brk_q <= 1'b1;
            end else begin
               key_valid <= 1'b1;
               key_break <= brk_q;
               scan_code <= sh_q;
               ext_q     <= 1'b0;
               brk_q     <= 1'b0;
               if (!brk_q) begin
                  keycode <= sh_q;
                  key_ext <= ext_q;
               end else if ({ext_q, sh_q} == {key_ext, keycode}) begin
                  keycode <= KEY_NONE;
                  key_ext <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Randomised bench for ps2_keycode_rx against a byte-level key model.
module tb_ps2_keycode_rx;

   localparam int HALF = 20;
   localparam int TMO  = 2000;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic       key_ext;
   logic       key_valid;
   logic       key_break;
   logic [7:0] scan_code;
   logic       frame_err;

   ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keycode   (keycode),
      .key_ext   (key_ext),
      .key_valid (key_valid),
      .key_break (key_break),
      .scan_code (scan_code),
      .frame_err (frame_err)
   );

   always #5 Clk = ~Clk;

   int         n_chk = 0;
   int         n_bad = 0;
   int         err_n = 0;
   int         m_err = 0;
   logic [8:0] ev_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] m_held = 8'h00;
   logic       m_hext = 1'b0;
   logic       m_ext = 1'b0;
   logic       m_brk = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (Reset === 1'b0) begin
         if (key_valid === 1'b1) ev_q.push_back({key_break, scan_code});
         if (frame_err === 1'b1) err_n++;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_stop,
                            input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_clk(HALF);
         ps2_clk = 1'b0;
         wait_clk(HALF);
         ps2_clk = 1'b1;
      end
      wait_clk(HALF);
      ps2_data = 1'b1;
   endtask

   // Key model: E0/F0 are prefixes, any other byte is a make or break.
   task automatic model_byte(input logic [7:0] b, input bit bad);
      if (bad) begin
         m_err++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         exp_q.push_back({m_brk, b});
         if (!m_brk) begin
            m_held = b;
            m_hext = m_ext;
         end else if (m_held == b && m_hext == m_ext) begin
            m_held = 8'h00;
            m_hext = 1'b0;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, ".nev"}, 32'(ev_q.size()), 32'(exp_q.size()));
      while (ev_q.size() > 0 && exp_q.size() > 0)
         chk({tag, ".ev"}, 32'(ev_q.pop_front()), 32'(exp_q.pop_front()));
      ev_q.delete();
      exp_q.delete();
      chk({tag, ".ferr"}, 32'(err_n), 32'(m_err));
      chk({tag, ".key"}, 32'(keycode), 32'(m_held));
      chk({tag, ".ext"}, 32'(key_ext), 32'(m_hext));
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_stop,
                        input bit bad_par, input string tag);
      model_byte(b, bad_stop || (PAR_EN && bad_par));
      send_bits(b, bad_stop, bad_par, 11);
      wait_clk(30);
      compare(tag);
   endtask

   logic [7:0] pick[4];
   logic [7:0] b;
   int         r;

   initial begin
      pick[0] = 8'h1C; pick[1] = 8'h1D; pick[2] = 8'h74; pick[3] = 8'h29;
      Reset = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      wait_clk(5);
      chk("rst.key", 32'(keycode), 32'h0);
      chk("rst.out", 32'({key_ext, key_valid, key_break, frame_err}), 32'h0);
      chk("rst.scan", 32'(scan_code), 32'h0);
      Reset = 1'b0;
      wait_clk(5);

      frame(8'h1C, 0, 0, "make1C");
      frame(8'hF0, 0, 0, "brkpre");
      frame(8'h1C, 0, 0, "brk1C");
      frame(8'hE0, 0, 0, "e0a");
      frame(8'h74, 0, 0, "make74");
      frame(8'hE0, 0, 0, "e0b");
      frame(8'hF0, 0, 0, "f0b");
      frame(8'h74, 0, 0, "brk74");
      frame(8'h1D, 0, 0, "ov1D");
      frame(8'h1C, 0, 0, "ov1C");
      frame(8'hF0, 0, 0, "ovF0");
      frame(8'h1D, 0, 0, "ovbrk");

      frame(8'hF0, 0, 0, "sF0");
      frame(8'h1C, 1, 0, "badstop");
      frame(8'h1C, 0, 0, "after");

      frame(8'hE0, 0, 0, "tE0");
      send_bits(8'h55, 0, 0, 4);
      wait_clk(TMO + 200);
      model_byte(8'h55, 1);
      compare("stall");
      frame(8'h74, 0, 0, "post74");
      frame(8'h29, 0, 0, "post29");

      frame(8'h1C, 0, 1, "badpar");

      ps2_data = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(3);
      ps2_clk = 1'b1;
      wait_clk(HALF);
      ps2_data = 1'b1;
      wait_clk(20);
      frame(8'h1D, 0, 0, "glitch");

      send_bits(8'hA5, 0, 0, 6);
      Reset = 1'b1;
      wait_clk(4);
      Reset = 1'b0;
      m_held = 8'h00;
      m_hext = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      wait_clk(TMO + 50);
      compare("midrst");
      frame(8'h29, 0, 0, "rstnext");

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) b = 8'hE0;
         else if (r < 4) b = 8'hF0;
         else if (r == 4) b = 8'($urandom);
         else b = pick[$urandom_range(0, 3)];
         frame(b, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               "rand");
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
